// File: rtl/chain_response_checker.sv
// Matches chain output transitions against pending stimulus transitions and reports errors.
// Define CHAIN_CHECK_MAXLAT_EN to track worst-case match latency on max_lat.
module chain_response_checker #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LAT_W   = 8,
    parameter int unsigned MAX_LAT = 16,
    parameter bit          INVERT  = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             stim_in,
    input  logic             chain_out,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             mismatch,
    output logic             timeout,
    output logic             spurious,
    output logic             overflow,
    output logic [LAT_W-1:0] last_lat,
    output logic [LAT_W-1:0] max_lat
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(MAX_LAT);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

    state_e           state_q, state_d;
    logic             prev_in_q, prev_in_d;
    logic             prev_out_q, prev_out_d;
    logic             exp_q [DEPTH];
    logic             exp_d [DEPTH];
    logic [LAT_W-1:0] age_q [DEPTH];
    logic [LAT_W-1:0] age_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             mismatch_q, mismatch_d;
    logic             timeout_q, timeout_d;
    logic             spurious_q, spurious_d;
    logic             overflow_q, overflow_d;
    logic [LAT_W-1:0] last_lat_q, last_lat_d;

    logic             active, in_edge, out_edge, empty, full;
    logic             head_exp;
    logic [LAT_W-1:0] head_age;
    logic             push, pop, pass_inc;
    logic [1:0]       err_inc;
    logic [CNT_W:0]   err_sum;

    assign active   = (state_q == StRun) && enable;
    assign in_edge  = active && (stim_in != prev_in_q);
    assign out_edge = active && (chain_out != prev_out_q);
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == FULL_CNT);
    assign head_exp = exp_q[rd_ptr_q];
    assign head_age = age_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        prev_in_d  = prev_in_q;
        prev_out_d = prev_out_q;
        exp_d      = exp_q;
        age_d      = age_q;
        last_lat_d = last_lat_q;
        overflow_d = overflow_q;
        mismatch_d = 1'b0;
        timeout_d  = 1'b0;
        spurious_d = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        pass_inc   = 1'b0;
        err_inc    = 2'd0;

        case (state_q)
            StIdle:  state_d = enable ? StArm : StIdle;
            StArm:   state_d = enable ? StRun : StIdle;
            StRun:   state_d = enable ? StRun : StIdle;
            default: state_d = StIdle;
        endcase

        if (state_q == StArm || state_q == StRun) begin
            prev_in_d  = stim_in;
            prev_out_d = chain_out;
        end

        // An output edge always wins the single pop slot over a timeout.
        if (out_edge) begin
            if (empty) begin
                spurious_d = 1'b1;
                err_inc    = err_inc + 2'd1;
            end else begin
                pop        = 1'b1;
                last_lat_d = head_age;
                if (chain_out == head_exp) begin
                    pass_inc = 1'b1;
                end else begin
                    mismatch_d = 1'b1;
                    err_inc    = err_inc + 2'd1;
                end
            end
        end else if (active && !empty && (head_age == LAT_MAX)) begin
            pop       = 1'b1;
            timeout_d = 1'b1;
            err_inc   = err_inc + 2'd1;
        end

        if (in_edge) begin
            if (full && !pop) begin
                overflow_d = 1'b1;
                err_inc    = err_inc + 2'd1;
            end else begin
                push = 1'b1;
            end
        end

        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_d[i] = (age_q[i] >= LAT_MAX) ? LAT_MAX : age_q[i] + 1'b1;
        end
        // Stored age is the age seen at the next evaluation, so a fresh entry holds 1.
        if (push) begin
            exp_d[wr_ptr_q] = stim_in ^ INVERT;
            age_d[wr_ptr_q] = LAT_W'(1);
        end

        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        cnt_d    = cnt_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        if (state_d == StIdle) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end

        pass_d  = (pass_inc && (pass_q != CNT_SAT)) ? pass_q + 1'b1 : pass_q;
        err_sum = {1'b0, err_q} + {{(CNT_W - 1){1'b0}}, err_inc};
        err_d   = err_sum[CNT_W] ? CNT_SAT : err_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            prev_in_q  <= 1'b0;
            prev_out_q <= 1'b0;
            exp_q      <= '{default: 1'b0};
            age_q      <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            pass_q     <= '0;
            err_q      <= '0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
            spurious_q <= 1'b0;
            overflow_q <= 1'b0;
            last_lat_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_in_q  <= prev_in_d;
            prev_out_q <= prev_out_d;
            exp_q      <= exp_d;
            age_q      <= age_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            mismatch_q <= mismatch_d;
            timeout_q  <= timeout_d;
            spurious_q <= spurious_d;
            overflow_q <= overflow_d;
            last_lat_q <= last_lat_d;
        end
    end

`ifdef CHAIN_CHECK_MAXLAT_EN
    logic [LAT_W-1:0] max_lat_q, max_lat_d;

    // Only real pops (match or mismatch) contribute; timeouts are excluded.
    always_comb begin
        max_lat_d = max_lat_q;
        if (out_edge && !empty && (head_age > max_lat_q)) begin
            max_lat_d = head_age;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_lat_q <= '0;
        end else begin
            max_lat_q <= max_lat_d;
        end
    end

    assign max_lat = max_lat_q;
`else
    assign max_lat = '0;
`endif

    assign pass_cnt = pass_q;
    assign err_cnt  = err_q;
    assign mismatch = mismatch_q;
    assign timeout  = timeout_q;
    assign spurious = spurious_q;
    assign overflow = overflow_q;
    assign last_lat = last_lat_q;

endmodule

// File: tb/tb_chain_response_checker.sv
// Bench for chain_response_checker: an INVERT=1 and an INVERT=0 instance share stimulus and are
// checked every cycle against a cycle-stamped transition-queue model, plus directed literals.
module tb_chain_response_checker;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LAT_W   = 8;
    localparam int unsigned MAX_LAT = 16;
    localparam int unsigned CNT_W   = 16;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef CHAIN_CHECK_MAXLAT_EN
    localparam int MAXLAT_T1 = 3;
`else
    localparam int MAXLAT_T1 = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             stim_in = 1'b0;
    logic             chain_out = 1'b1;
    logic [CNT_W-1:0] pass_cnt [2];
    logic [CNT_W-1:0] err_cnt  [2];
    logic             mismatch [2];
    logic             timeout  [2];
    logic             spurious [2];
    logic             overflow [2];
    logic [LAT_W-1:0] last_lat [2];
    logic [LAT_W-1:0] max_lat  [2];

    // Index 1 expects an inverting chain, index 0 a non-inverting one.
    chain_response_checker #(
        .DEPTH(DEPTH), .LAT_W(LAT_W), .MAX_LAT(MAX_LAT), .INVERT(1'b1), .CNT_W(CNT_W)
    ) dut_inv (
        .clk(clk), .rst_n(rst_n), .enable(enable), .stim_in(stim_in), .chain_out(chain_out),
        .pass_cnt(pass_cnt[1]), .err_cnt(err_cnt[1]), .mismatch(mismatch[1]),
        .timeout(timeout[1]), .spurious(spurious[1]), .overflow(overflow[1]),
        .last_lat(last_lat[1]), .max_lat(max_lat[1])
    );

    chain_response_checker #(
        .DEPTH(DEPTH), .LAT_W(LAT_W), .MAX_LAT(MAX_LAT), .INVERT(1'b0), .CNT_W(CNT_W)
    ) dut_buf (
        .clk(clk), .rst_n(rst_n), .enable(enable), .stim_in(stim_in), .chain_out(chain_out),
        .pass_cnt(pass_cnt[0]), .err_cnt(err_cnt[0]), .mismatch(mismatch[0]),
        .timeout(timeout[0]), .spurious(spurious[0]), .overflow(overflow[0]),
        .last_lat(last_lat[0]), .max_lat(max_lat[0])
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: each pending transition remembers the cycle it was seen and its expected value.
    int  cyc = 0;
    int  m_mode [2];
    bit  m_prev_in [2];
    bit  m_prev_out [2];
    int  q_pc [2][DEPTH];
    bit  q_ex [2][DEPTH];
    int  q_n [2];
    int  m_pass [2];
    int  m_err [2];
    bit  m_mis [2];
    bit  m_to [2];
    bit  m_sp [2];
    bit  m_ovf [2];
    int  m_last [2];
    int  m_max [2];

    task automatic pop_front(input int k);
        for (int j = 0; j < q_n[k] - 1; j++) begin
            q_pc[k][j] = q_pc[k][j+1];
            q_ex[k][j] = q_ex[k][j+1];
        end
        q_n[k]--;
    endtask

    task automatic model_step(input int k);
        bit in_e, out_e;
        int errs, age;
        if (!rst_n) begin
            m_mode[k] = 0; q_n[k] = 0; m_prev_in[k] = 0; m_prev_out[k] = 0;
            m_pass[k] = 0; m_err[k] = 0; m_mis[k] = 0; m_to[k] = 0; m_sp[k] = 0;
            m_ovf[k] = 0; m_last[k] = 0; m_max[k] = 0;
            return;
        end
        m_mis[k] = 0; m_to[k] = 0; m_sp[k] = 0; errs = 0;
        if (m_mode[k] == 2 && enable) begin
            in_e  = (stim_in != m_prev_in[k]);
            out_e = (chain_out != m_prev_out[k]);
            if (out_e) begin
                if (q_n[k] == 0) begin
                    m_sp[k] = 1; errs++;
                end else begin
                    age = cyc - q_pc[k][0];
                    if (age > int'(MAX_LAT)) age = MAX_LAT;
                    m_last[k] = age;
                    if (chain_out == q_ex[k][0]) begin
                        if (m_pass[k] < CNT_MAX) m_pass[k]++;
                    end else begin
                        m_mis[k] = 1; errs++;
                    end
`ifdef CHAIN_CHECK_MAXLAT_EN
                    if (age > m_max[k]) m_max[k] = age;
`endif
                    pop_front(k);
                end
            end else if (q_n[k] > 0 && (cyc - q_pc[k][0]) >= int'(MAX_LAT)) begin
                m_to[k] = 1; errs++;
                pop_front(k);
            end
            if (in_e) begin
                if (q_n[k] == int'(DEPTH)) begin
                    m_ovf[k] = 1; errs++;
                end else begin
                    q_pc[k][q_n[k]] = cyc;
                    q_ex[k][q_n[k]] = stim_in ^ (k == 1);
                    q_n[k]++;
                end
            end
            m_err[k] = (m_err[k] + errs > CNT_MAX) ? CNT_MAX : m_err[k] + errs;
        end
        if (m_mode[k] != 0) begin
            m_prev_in[k]  = stim_in;
            m_prev_out[k] = chain_out;
        end
        if (!enable) m_mode[k] = 0;
        else if (m_mode[k] == 0) m_mode[k] = 1;
        else m_mode[k] = 2;
        if (m_mode[k] == 0) q_n[k] = 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
    end

    int mis_seen = 0;
    int sp_seen  = 0;

    // Single compare process: all outputs of both instances, every cycle after the first edge.
    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("pass_cnt%0d", k), int'(pass_cnt[k]), m_pass[k]);
                chk($sformatf("err_cnt%0d", k), int'(err_cnt[k]), m_err[k]);
                chk($sformatf("mismatch%0d", k), int'(mismatch[k]), int'(m_mis[k]));
                chk($sformatf("timeout%0d", k), int'(timeout[k]), int'(m_to[k]));
                chk($sformatf("spurious%0d", k), int'(spurious[k]), int'(m_sp[k]));
                chk($sformatf("overflow%0d", k), int'(overflow[k]), int'(m_ovf[k]));
                chk($sformatf("last_lat%0d", k), int'(last_lat[k]), m_last[k]);
                chk($sformatf("max_lat%0d", k), int'(max_lat[k]), m_max[k]);
            end
            if (mismatch[0]) mis_seen++;
            if (spurious[1]) sp_seen++;
        end
    end

    // Stimulus: values are applied at the falling edge; the chain is a 3-cycle inverting delay
    // unless held, in which case chain_out follows cf_v.
    bit rst_v = 0, en_v = 0, s_v = 0, hold_v = 0, cf_v = 1, inv_v = 1;
    bit hist [8];

    task automatic step();
        @(negedge clk);
        rst_n   = rst_v;
        enable  = en_v;
        stim_in = s_v;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = s_v;
        chain_out = hold_v ? cf_v : (hist[3] ^ inv_v);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input bit hold);
        rst_v = 0; en_v = 0; hold_v = hold; cf_v = s_v ^ inv_v;
        steps(5);
        rst_v = 1;
        step();
        en_v = 1;
        steps(4);
    endtask

    initial begin
        int first;
        for (int i = 0; i < 8; i++) hist[i] = 0;
        rst_v = 0; en_v = 0;
        steps(5);
        rst_v = 1;
        step();
        chk("reset pass_cnt", int'(pass_cnt[1]), 0);
        chk("reset err_cnt", int'(err_cnt[1]), 0);
        chk("reset overflow", int'(overflow[1]), 0);
        chk("reset last_lat", int'(last_lat[1]), 0);

        // Matched transitions through a 3-cycle inverting chain.
        en_v = 1;
        steps(4);
        for (int e = 0; e < 10; e++) begin
            s_v = ~s_v;
            steps(8);
        end
        steps(4);
        chk("t1 pass_cnt", int'(pass_cnt[1]), 10);
        chk("t1 err_cnt", int'(err_cnt[1]), 0);
        chk("t1 last_lat", int'(last_lat[1]), 3);
        chk("t1 max_lat", int'(max_lat[1]), MAXLAT_T1);
        chk("t1 noninv err_cnt", int'(err_cnt[0]), 10);

        // Wrong polarity: INVERT=0 instance sees every transition as a mismatch.
        do_reset(0);
        mis_seen = 0;
        for (int e = 0; e < 4; e++) begin
            s_v = ~s_v;
            steps(8);
        end
        steps(4);
        chk("t2 mismatch pulses", mis_seen, 4);
        chk("t2 pass_cnt", int'(pass_cnt[0]), 0);
        chk("t2 err_cnt", int'(err_cnt[0]), 4);
        chk("t2 inv pass_cnt", int'(pass_cnt[1]), 4);

        // Stalled chain: single entry must time out 16 cycles after its push.
        do_reset(1);
        s_v = ~s_v;
        step();
        first = -1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (timeout[1] && first < 0) first = i;
        end
        chk("t3 timeout delay", first, 16);
        chk("t3 err_cnt", int'(err_cnt[1]), 1);
        cf_v = ~cf_v;
        steps(2);
        chk("t3 fifo empty", int'(spurious[1]), 1);
        chk("t3 err_cnt after", int'(err_cnt[1]), 2);

        // Output edge with nothing pending.
        do_reset(1);
        sp_seen = 0;
        cf_v = ~cf_v;
        steps(3);
        chk("t4 spurious pulses", sp_seen, 1);
        chk("t4 err_cnt", int'(err_cnt[1]), 1);
        chk("t4 pass_cnt", int'(pass_cnt[1]), 0);

        // Five pushes into a four-deep FIFO, then the chain releases four edges.
        do_reset(1);
        for (int e = 0; e < 5; e++) begin
            s_v = ~s_v;
            step();
        end
        step();
        chk("t5 overflow", int'(overflow[1]), 1);
        chk("t5 err_cnt", int'(err_cnt[1]), 1);
        for (int e = 0; e < 4; e++) begin
            cf_v = ~cf_v;
            step();
        end
        steps(3);
        chk("t5 pass_cnt", int'(pass_cnt[1]), 4);
        chk("t5 err_cnt after", int'(err_cnt[1]), 1);
        chk("t5 overflow sticky", int'(overflow[1]), 1);
        chk("t5 noninv err_cnt", int'(err_cnt[0]), 5);

        // Reset with two entries pending, then re-enable and toggle during ARM.
        for (int e = 0; e < 2; e++) begin
            s_v = ~s_v;
            step();
        end
        rst_v = 0; en_v = 0;
        step();
        rst_v = 1;
        step();
        chk("t6 pass_cnt", int'(pass_cnt[1]), 0);
        chk("t6 err_cnt", int'(err_cnt[1]), 0);
        chk("t6 overflow", int'(overflow[1]), 0);
        chk("t6 last_lat", int'(last_lat[1]), 0);
        en_v = 1;
        step();
        s_v = ~s_v;
        cf_v = ~cf_v;
        step();
        step();
        chk("t6 arm spurious", int'(spurious[1]), 0);
        steps(20);
        chk("t6 err_cnt after", int'(err_cnt[1]), 0);
        chk("t6 timeout", int'(timeout[1]), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
